// File: rtl/irq_chain_pkg.sv
// Shared constants for the irq_chain daisy-chained interrupt controller.
// Register addresses and channel limits used by the top and the bench.
package irq_chain_pkg;

    localparam int MAX_CH = 8;

    localparam logic [2:0] REG_MASK = 3'd0;
    localparam logic [2:0] REG_PEND = 3'd1;
    localparam logic [2:0] REG_ISR  = 3'd2;
    localparam logic [2:0] REG_BASE = 3'd3;
    localparam logic [2:0] REG_MODE = 3'd4;

    function automatic logic [7:0] ch_bits(input int n);
        return 8'((1 << n) - 1);
    endfunction

endpackage

// File: rtl/irq_chain_sync.sv
// Per-channel two-flop synchroniser plus edge-detect flop.
// lvl is the synchronised source, rise pulses for one cycle on a rising edge.
module irq_chain_sync (
    input  logic clk_sys,
    input  logic reset,
    input  logic src,
    output logic lvl,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= src;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_chain.sv
// Mode-2 style daisy-chained interrupt controller with fixed priority.
// Optional level-sensitive channels when IRQ_CHAIN_LEVEL_EN is defined.
module irq_chain
    import irq_chain_pkg::*;
#(
    parameter int         NCH     = 4,
    parameter logic [7:0] VEC_RST = 8'h08
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic [NCH-1:0] src_i,
    input  logic           cs_n,
    input  logic           rd_n,
    input  logic           wr_n,
    input  logic [2:0]     a,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic           doe,
    input  logic           m1_n,
    input  logic           iorq_n,
    input  logic           reti_i,
    input  logic           iei,
    output logic           ieo,
    output logic           int_n,
    output logic [7:0]     vec_o,
    output logic           vec_oe
);

    localparam logic [7:0] CH_MASK = ch_bits(NCH);

    logic [7:0] mask;
    logic [7:0] pending;
    logic [7:0] inservice;
    logic [7:0] base;
    logic [7:0] mode;
    logic [7:0] lvl;
    logic [7:0] rise;
    logic       ack_q;
    logic       reti_q;

    for (genvar ch = 0; ch < MAX_CH; ch++) begin : g_ch
        if (ch < NCH) begin : g_on
            irq_chain_sync u_sync (
                .clk_sys (clk_sys),
                .reset   (reset),
                .src     (src_i[ch]),
                .lvl     (lvl[ch]),
                .rise    (rise[ch])
            );
        end else begin : g_off
            assign lvl[ch]  = 1'b0;
            assign rise[ch] = 1'b0;
        end
    end

    logic       wr_en;
    logic [7:0] pend_m;
    logic [3:0] top_is;
    logic       cand_ok;
    logic [2:0] cand_ch;
    logic       ack_go;
    logic       reti_go;
    logic [7:0] ack_bit;
    logic [7:0] reti_bit;
    logic [7:0] w1c;
    logic [7:0] is_next;
    logic [7:0] pend_next;

    assign wr_en  = ~cs_n & ~wr_n;
    assign pend_m = pending & ~mask;

    // top_is = 8 means nothing in service, so any candidate qualifies
    always_comb begin
        top_is  = 4'd8;
        cand_ok = 1'b0;
        cand_ch = 3'd0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (inservice[i]) top_is = 4'(i);
        end
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (pend_m[i] && (4'(i) < top_is)) begin
                cand_ok = 1'b1;
                cand_ch = 3'(i);
            end
        end
    end

    assign ack_go   = ~m1_n & ~iorq_n & ~ack_q & cand_ok & iei;
    assign reti_go  = reti_i & ~reti_q & iei;
    assign ack_bit  = ack_go ? (8'd1 << cand_ch) : 8'd0;
    assign reti_bit = reti_go ? (inservice & (~inservice + 8'd1)) : 8'd0;
    assign w1c      = (wr_en && (a == REG_PEND)) ? din : 8'd0;
    assign is_next  = ((inservice & ~reti_bit) | ack_bit) & CH_MASK;

    always_comb begin
        pend_next = 8'd0;
        for (int i = 0; i < MAX_CH; i++) begin
            pend_next[i] = pending[i] & ~ack_bit[i];
            if (mode[i]) begin
                if (!is_next[i])
                    pend_next[i] = lvl[i];
                else if (!lvl[i])
                    pend_next[i] = pend_next[i] & ~w1c[i];
            end else begin
                pend_next[i] = (pend_next[i] & ~w1c[i]) | rise[i];
            end
        end
        pend_next = pend_next & CH_MASK;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mask      <= CH_MASK;
            pending   <= 8'd0;
            inservice <= 8'd0;
            base      <= VEC_RST;
            int_n     <= 1'b1;
            vec_o     <= 8'd0;
            vec_oe    <= 1'b0;
            ack_q     <= 1'b0;
            reti_q    <= 1'b0;
        end else begin
            ack_q     <= ~m1_n & ~iorq_n;
            reti_q    <= reti_i;
            pending   <= pend_next;
            inservice <= is_next;
            int_n     <= ~(cand_ok & iei);
            if (ack_go) begin
                vec_o  <= base + {4'd0, cand_ch, 1'b0};
                vec_oe <= 1'b1;
            end else if (m1_n || iorq_n) begin
                vec_oe <= 1'b0;
            end
            if (wr_en && (a == REG_MASK)) mask <= din & CH_MASK;
            if (wr_en && (a == REG_BASE)) base <= {din[7:1], 1'b0};
        end
    end

`ifdef IRQ_CHAIN_LEVEL_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            mode <= 8'd0;
        else if (wr_en && (a == REG_MODE))
            mode <= din & CH_MASK;
    end
`else
    assign mode = 8'd0;
`endif

    always_comb begin
        dout = 8'd0;
        unique case (1'b1)
            (a == REG_MASK): dout = mask;
            (a == REG_PEND): dout = pending;
            (a == REG_ISR):  dout = inservice;
            (a == REG_BASE): dout = base;
            (a == REG_MODE): dout = mode;
            default:         dout = 8'd0;
        endcase
    end

    assign doe = ~cs_n & ~rd_n;
    assign ieo = iei & ~(|inservice) & ~(|pend_m);

endmodule

// File: tb/tb_irq_chain.sv
// Directed scoreboard bench for irq_chain (define IRQ_CHAIN_LEVEL_EN
// to also exercise level-mode channels).
module tb_irq_chain;
    import irq_chain_pkg::*;

    localparam int NCH = 4;

    logic           clk_sys = 1'b0;
    logic           reset   = 1'b1;
    logic [NCH-1:0] src_i   = '0;
    logic           cs_n    = 1'b1;
    logic           rd_n    = 1'b1;
    logic           wr_n    = 1'b1;
    logic [2:0]     a       = 3'd0;
    logic [7:0]     din     = 8'd0;
    logic [7:0]     dout;
    logic           doe;
    logic           m1_n    = 1'b1;
    logic           iorq_n  = 1'b1;
    logic           reti_i  = 1'b0;
    logic           iei     = 1'b1;
    logic           ieo;
    logic           int_n;
    logic [7:0]     vec_o;
    logic           vec_oe;

    irq_chain #(.NCH(NCH), .VEC_RST(8'h08)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .src_i   (src_i),
        .cs_n    (cs_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .a       (a),
        .din     (din),
        .dout    (dout),
        .doe     (doe),
        .m1_n    (m1_n),
        .iorq_n  (iorq_n),
        .reti_i  (reti_i),
        .iei     (iei),
        .ieo     (ieo),
        .int_n   (int_n),
        .vec_o   (vec_o),
        .vec_oe  (vec_oe)
    );

    always #5 clk_sys = ~clk_sys;

    int         checks = 0;
    int         errors = 0;
    string      tq[$];
    logic [7:0] vq[$];

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] v);
        tq.push_back(tag);
        vq.push_back(v);
    endtask

    task automatic pop(input logic [7:0] obs);
        if (vq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty got %h want none", obs);
        end else begin
            chk(tq.pop_front(), obs, vq.pop_front());
        end
    endtask

    task automatic clk(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic rd(input logic [2:0] addr, output logic [7:0] d);
        cs_n = 1'b0;
        rd_n = 1'b0;
        a    = addr;
        #1;
        d    = dout;
        cs_n = 1'b1;
        rd_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] d);
        cs_n = 1'b0;
        wr_n = 1'b0;
        a    = addr;
        din  = d;
        clk();
        cs_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        src_i  = '0;
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        reti_i = 1'b0;
        iei    = 1'b1;
        clk(2);
        reset  = 1'b0;
        clk();
    endtask

    task automatic ack_on();
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        clk();
    endtask

    task automatic ack_off();
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        clk();
    endtask

    task automatic reti_pulse();
        reti_i = 1'b1;
        clk();
        reti_i = 1'b0;
        clk();
    endtask

    logic [7:0] d;

    initial begin
        // reset state
        clk(2);
        push("rst_int_n", 8'h01);
        push("rst_vec_oe", 8'h00);
        push("rst_vec_o", 8'h00);
        push("rst_mask", 8'h0F);
        push("rst_base", 8'h08);
        push("rst_ieo", 8'h01);
        pop({7'd0, int_n});
        pop({7'd0, vec_oe});
        pop(vec_o);
        rd(REG_MASK, d); pop(d);
        rd(REG_BASE, d); pop(d);
        pop({7'd0, ieo});
        reset = 1'b0;
        clk();

        // scenario 1: single channel request and acknowledge
        wr(REG_MASK, 8'h0E);
        src_i = 4'b0001;
        push("s1_pend", 8'h01);
        push("s1_int_n3", 8'h01);
        clk(3);
        rd(REG_PEND, d); pop(d);
        pop({7'd0, int_n});
        push("s1_int_n4", 8'h00);
        push("s1_ieo", 8'h00);
        clk();
        src_i = '0;
        pop({7'd0, int_n});
        pop({7'd0, ieo});
        push("s1_vec_oe", 8'h01);
        push("s1_vec_o", 8'h08);
        push("s1_isr", 8'h01);
        push("s1_pend_clr", 8'h00);
        ack_on();
        pop({7'd0, vec_oe});
        pop(vec_o);
        rd(REG_ISR, d); pop(d);
        rd(REG_PEND, d); pop(d);
        push("s1_int_n_hi", 8'h01);
        push("s1_vec_oe_hold", 8'h01);
        clk();
        pop({7'd0, int_n});
        pop({7'd0, vec_oe});
        push("s1_vec_oe_end", 8'h00);
        ack_off();
        pop({7'd0, vec_oe});
        push("s1_reti", 8'h00);
        reti_pulse();
        rd(REG_ISR, d); pop(d);

        // register map odds and ends
        push("doe_rd", 8'h01);
        cs_n = 1'b0; rd_n = 1'b0; #1;
        pop({7'd0, doe});
        cs_n = 1'b1; rd_n = 1'b1; #1;
        push("doe_idle", 8'h00);
        pop({7'd0, doe});
        push("addr5", 8'h00);
        rd(3'd5, d); pop(d);
`ifndef IRQ_CHAIN_LEVEL_EN
        wr(REG_MODE, 8'hFF);
        push("addr4_dflt", 8'h00);
        rd(REG_MODE, d); pop(d);
`endif

        // scenario 2: nesting below an in-service channel
        do_reset();
        wr(REG_BASE, 8'h41);
        push("s2_base", 8'h40);
        rd(REG_BASE, d); pop(d);
        wr(REG_MASK, 8'h00);
        src_i = 4'b0100;
        clk(3);
        src_i = '0;
        clk();
        push("s2_vec_ch2", 8'h44);
        ack_on();
        pop(vec_o);
        ack_off();
        clk();
        src_i = 4'b1010;
        clk(3);
        src_i = '0;
        push("s2_int_n_ch1", 8'h00);
        clk();
        pop({7'd0, int_n});
        push("s2_vec_ch1", 8'h42);
        push("s2_isr_nest", 8'h06);
        ack_on();
        pop(vec_o);
        rd(REG_ISR, d); pop(d);
        ack_off();
        clk();
        push("s2_int_n_blk", 8'h01);
        pop({7'd0, int_n});
        push("s2_reti1", 8'h04);
        push("s2_int_n_blk2", 8'h01);
        reti_pulse();
        rd(REG_ISR, d); pop(d);
        pop({7'd0, int_n});
        push("s2_reti2", 8'h00);
        push("s2_int_n_ch3", 8'h00);
        reti_pulse();
        rd(REG_ISR, d); pop(d);
        pop({7'd0, int_n});
        push("s2_vec_ch3", 8'h46);
        ack_on();
        pop(vec_o);
        ack_off();

        // scenario 3: chain disabled upstream
        do_reset();
        iei = 1'b0;
        wr(REG_MASK, 8'h00);
        src_i = 4'b0001;
        clk(3);
        src_i = '0;
        clk();
        push("s3_int_n", 8'h01);
        push("s3_ieo", 8'h00);
        pop({7'd0, int_n});
        pop({7'd0, ieo});
        push("s3_vec_oe", 8'h00);
        push("s3_pend", 8'h01);
        push("s3_isr", 8'h00);
        push("s3_vec_o", 8'h00);
        ack_on();
        pop({7'd0, vec_oe});
        rd(REG_PEND, d); pop(d);
        rd(REG_ISR, d); pop(d);
        pop(vec_o);
        ack_off();
        iei = 1'b1;

        // scenario 4: W1C colliding with a new edge
        do_reset();
        wr(REG_MASK, 8'h00);
        src_i = 4'b0010;
        clk(3);
        src_i = '0;
        clk(3);
        src_i = 4'b0010;
        clk(2);
        push("s4_set_wins", 8'h02);
        wr(REG_PEND, 8'h02);
        rd(REG_PEND, d); pop(d);
        src_i = '0;
        push("s4_w1c", 8'h00);
        wr(REG_PEND, 8'h02);
        rd(REG_PEND, d); pop(d);

        // scenario 5: reset in the middle of an acknowledge
        do_reset();
        wr(REG_MASK, 8'h00);
        wr(REG_BASE, 8'h80);
        src_i = 4'b0001;
        clk(3);
        src_i = '0;
        clk();
        push("s5_vec_oe_on", 8'h01);
        ack_on();
        pop({7'd0, vec_oe});
        reset = 1'b1;
        #1;
        push("s5_vec_oe", 8'h00);
        push("s5_int_n", 8'h01);
        push("s5_vec_o", 8'h00);
        push("s5_mask", 8'h0F);
        push("s5_pend", 8'h00);
        push("s5_isr", 8'h00);
        push("s5_base", 8'h08);
        pop({7'd0, vec_oe});
        pop({7'd0, int_n});
        pop(vec_o);
        rd(REG_MASK, d); pop(d);
        rd(REG_PEND, d); pop(d);
        rd(REG_ISR, d); pop(d);
        rd(REG_BASE, d); pop(d);
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        clk();
        reset = 1'b0;
        clk();

`ifdef IRQ_CHAIN_LEVEL_EN
        // scenario 6: level-mode channel
        do_reset();
        wr(REG_MODE, 8'h01);
        push("s6_mode", 8'h01);
        rd(REG_MODE, d); pop(d);
        wr(REG_MASK, 8'h0E);
        src_i = 4'b0001;
        clk(3);
        push("s6_pend", 8'h01);
        rd(REG_PEND, d); pop(d);
        push("s6_w1c_ign", 8'h01);
        wr(REG_PEND, 8'h01);
        rd(REG_PEND, d); pop(d);
        clk();
        push("s6_isr", 8'h01);
        push("s6_pend_ack", 8'h00);
        ack_on();
        rd(REG_ISR, d); pop(d);
        rd(REG_PEND, d); pop(d);
        ack_off();
        reti_i = 1'b1;
        push("s6_repend", 8'h01);
        clk();
        rd(REG_PEND, d); pop(d);
        reti_i = 1'b0;
        clk();
        src_i = '0;
`endif

        if (vq.size() != 0) begin
            errors++;
            $display("FAIL sb_left got %0d want 0", vq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_chain.md
IRQ_CHAIN -- requirements
Module: irq_chain

Interface
REQ-001 SHALL have parameter NCH, default 4, number of interrupt channels (1..8).
REQ-002 SHALL have parameter VEC_RST, default 8'h08, reset value of the vector base register.
REQ-003 SHALL have these ports, in this order:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- src_i  in  NCH  raw interrupt sources, asynchronous to clk_sys.
- cs_n  in  1  register select, active-low.
- rd_n, wr_n  in  1 each  CPU strobes, active-low.
- a  in  3  register address.
- din  in  8  CPU write data.
- dout  out  8  register read data.
- doe  out  1  dout valid, high when cs_n=0 and rd_n=0.
- m1_n, iorq_n  in  1 each  CPU cycle-type strobes.
- reti_i  in  1  RETI indication.
- iei  in  1  daisy-chain enable in.
- ieo  out  1  daisy-chain enable out.
- int_n  out  1  interrupt request, active-low, registered.
- vec_o  out  8  mode-2 vector.
- vec_oe  out  1  vector valid during acknowledge.

Function
REQ-004 Each src_i bit SHALL pass a 2-flop synchroniser followed by an edge-detect flop; a rising edge SHALL set pending[ch] on the 3rd clk_sys edge after src_i is first sampled high.
REQ-005 Register map:
- 0 = mask, RW; 1 = masked.
- 1 = pending, R; write-1-to-clear.
- 2 = in-service, RO.
- 3 = vector base, RW; bit 0 forced 0.
- 4..7 read 8'h00, writes ignored (except REQ-017).
- Bits at or above NCH read 0.
REQ-006 Register writes SHALL occur on the clk_sys edge where cs_n=0 and wr_n=0; dout SHALL be combinational from the addressed register.
REQ-007 Priority SHALL be fixed: channel 0 is highest.
REQ-008 The request candidate SHALL be the lowest-index ch with pending=1 and mask=0 whose index is lower than the highest-priority in-service channel (any index if none in service).
REQ-009 int_n SHALL be registered, low one cycle after a candidate exists with iei=1, high otherwise.
REQ-010 Acknowledge start SHALL be the first clk_sys edge with m1_n=0 and iorq_n=0 after either was high.
REQ-011 At acknowledge start with a valid candidate and iei=1, the block SHALL latch vec_o = base + 2*ch, clear pending[ch], set inservice[ch], and hold vec_oe=1 until m1_n or iorq_n rises.
REQ-012 An acknowledge with no candidate or iei=0 SHALL leave all state unchanged with vec_oe=0.
REQ-013 On a reti_i rising edge (clk_sys-sampled) with iei=1, the block SHALL clear the highest-priority in-service bit; with none in service it SHALL do nothing.
REQ-014 ieo SHALL equal iei AND no in-service bit AND no unmasked pending bit (combinational).
REQ-015 Simultaneous events:
- Edge and W1C on the same channel in the same cycle: set wins.
- Edge during in-service: re-pends.
- Masking does not clear pending.
- Ack and register write in the same cycle: ack applies first, then the write.

Reset
REQ-016 Reset values:
- mask = all 1.
- pending = 0, in-service = 0.
- base = VEC_RST.
- int_n = 1, vec_oe = 0, vec_o = 0.
- Synchroniser and edge flops = 0.
- Reset mid-acknowledge aborts it immediately.

Configuration
REQ-017 With IRQ_CHAIN_LEVEL_EN defined:
- Address 4 is a RW mode register, reset 0.
- mode[ch]=1 is level mode: pending[ch] tracks the synchronised source while not in service, and W1C is ignored while the source is high.
Without the macro, address 4 reads 0 and all channels are edge mode.

Structure
REQ-018 Package irq_chain_pkg SHALL hold the register address constants (REG_MASK..REG_MODE) and the maximum channel constant.
REQ-019 The per-channel synchroniser and edge detector SHALL be sub-module irq_chain_sync, instantiated NCH times.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, write mask=8'h0E, pulse src_i[0] -> pending=8'h01 after 3 cycles, int_n low after 4; ack -> vec_o=8'h08, vec_oe=1, inservice=8'h01, int_n high.
- Base=8'h40, ch2 in service, pend ch3 and ch1 -> int_n low for ch1 only; ack -> vec_o=8'h42; reti -> inservice=8'h04; second reti -> 8'h00, int_n low for ch3, vec_o=8'h46.
- iei=0 with ch0 pending unmasked -> int_n high, ieo=0, ack gives vec_oe=0, state unchanged.
- W1C pending ch1 in the same cycle as a ch1 edge -> pending[1] remains 1.
- Reset asserted during an ack -> vec_oe=0 and int_n=1 in the same cycle, all registers at reset values.
- With IRQ_CHAIN_LEVEL_EN, mode=8'h01 and src_i[0] held high -> W1C ignored; after ack and reti, re-pend within 1 cycle.
